// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared types for the program loader: FSM state enum (whose encoding is also
// the value shown on the State display output) and the Cmd encodings.
// -----------------------------------------------------------------------------
package prog_loader_pkg;

   localparam int STATE_W = 3;

   // Encoding doubles as the State output value shown on the display.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_WRITE  = 3'd1,
      ST_VERIFY = 3'd2,
      ST_READ   = 3'd3
   } state_e;

   typedef enum logic [1:0] {
      CMD_SETADDR = 2'b00,
      CMD_WRITE   = 2'b01,
      CMD_READ    = 2'b10,
      CMD_CLEAR   = 2'b11
   } cmd_e;

endpackage : prog_loader_pkg

// File: rtl/ack_timer.sv
// -----------------------------------------------------------------------------
// ack_timer
// Restartable acknowledge timeout. i_start arms the timer (and restarts it if
// already running); i_ack disarms it. o_expired is high in the last cycle of a
// TIMEOUT-cycle wait with no ack, so the owner can abort on that clock edge.
// Ports:
//   Clk        system clock
//   Reset_n    asynchronous active-low reset
//   i_start    arm/restart pulse, issued on the edge that raises the request
//   i_ack      memory acknowledge (ends the wait)
//   o_expired  request has been outstanding for TIMEOUT cycles
// -----------------------------------------------------------------------------
module ack_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic i_start,
   input  logic i_ack,
   output logic o_expired
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   logic             r_active;
   logic [CNT_W-1:0] r_count;

   // Count 0 is the first request cycle, so expiry lands on cycle TIMEOUT.
   // An ack in that same cycle still wins.
   assign o_expired = r_active && !i_ack && (r_count == CNT_W'(TIMEOUT - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_active <= 1'b0;
         r_count  <= '0;
      end else if (i_start) begin
         r_active <= 1'b1;
         r_count  <= '0;
      end else if (i_ack || o_expired) begin
         r_active <= 1'b0;
      end else if (r_active) begin
         r_count  <= r_count + 1'b1;
      end
   end

endmodule : ack_timer

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Front-panel program loader: commands strobed from a key filter set a load
// pointer, write switch words into instruction memory, read words back for
// display, and clear status. The processor is held while a transfer is busy.
// Optional build macro PROG_LOADER_VERIFY_EN adds a read-back VERIFY after
// every WRITE; a mismatch sets the sticky Error flag.
// Ports:
//   Clk, Reset_n      clock, asynchronous active-low reset
//   Strobe, Cmd, Sw   one-cycle command pulse, command code, switch value
//   MemAddr/MemWrData memory address and write data
//   MemWe/MemRe       write/read requests, held until MemAck or timeout
//   MemAck/MemRdData  one-cycle acknowledge and read data from memory
//   RdData            last word read (display)
//   Ptr, WordCount    load pointer, saturating count of words written
//   ProcHold, Error   processor hold, sticky timeout/verify error
//   State             encoded FSM state (display)
// -----------------------------------------------------------------------------
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 16,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               Strobe,
   input  logic [1:0]         Cmd,
   input  logic [DATA_W-1:0]  Sw,
   output logic [ADDR_W-1:0]  MemAddr,
   output logic [DATA_W-1:0]  MemWrData,
   output logic               MemWe,
   output logic               MemRe,
   input  logic               MemAck,
   input  logic [DATA_W-1:0]  MemRdData,
   output logic [DATA_W-1:0]  RdData,
   output logic [ADDR_W-1:0]  Ptr,
   output logic [7:0]         WordCount,
   output logic               ProcHold,
   output logic               Error,
   output logic [STATE_W-1:0] State
);

   state_e            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [7:0]        r_word_count;
   logic              r_error;
   logic [DATA_W-1:0] r_rd_data;
   logic [DATA_W-1:0] r_wr_data;

   state_e w_next_state;
   logic   w_ld_ptr;
   logic   w_ld_wr;
   logic   w_inc_ptr;
   logic   w_cap_rd;
   logic   w_set_err;
   logic   w_clr;
   logic   w_start;
   logic   w_expired;

   ack_timer #(
      .TIMEOUT (ACK_TIMEOUT)
   ) u_ack_timer (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .i_start   (w_start),
      .i_ack     (MemAck),
      .o_expired (w_expired)
   );

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_ld_ptr     = 1'b0;
      w_ld_wr      = 1'b0;
      w_inc_ptr    = 1'b0;
      w_cap_rd     = 1'b0;
      w_set_err    = 1'b0;
      w_clr        = 1'b0;
      w_start      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // MemAck is deliberately not looked at here.
            if (Strobe) begin
               case (cmd_e'(Cmd))
                  CMD_SETADDR: w_ld_ptr = 1'b1;
                  CMD_WRITE: begin
                     w_ld_wr      = 1'b1;
                     w_start      = 1'b1;
                     w_next_state = ST_WRITE;
                  end
                  CMD_READ: begin
                     w_start      = 1'b1;
                     w_next_state = ST_READ;
                  end
                  default: w_clr = 1'b1;   // CMD_CLEAR
               endcase
            end
         end

         ST_WRITE: begin
            if (MemAck) begin
               w_inc_ptr = 1'b1;
`ifdef PROG_LOADER_VERIFY_EN
               w_start      = 1'b1;
               w_next_state = ST_VERIFY;
`else
               w_next_state = ST_IDLE;
`endif
            end else if (w_expired) begin
               w_set_err    = 1'b1;
               w_next_state = ST_IDLE;
            end
         end

`ifdef PROG_LOADER_VERIFY_EN
         ST_VERIFY: begin
            if (MemAck) begin
               w_cap_rd     = 1'b1;
               w_set_err    = (MemRdData != r_wr_data);
               w_next_state = ST_IDLE;
            end else if (w_expired) begin
               w_set_err    = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
`endif

         ST_READ: begin
            if (MemAck) begin
               w_cap_rd     = 1'b1;
               w_next_state = ST_IDLE;
            end else if (w_expired) begin
               w_set_err    = 1'b1;
               w_next_state = ST_IDLE;
            end
         end

         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_word_count <= '0;
         r_error      <= 1'b0;
         r_rd_data    <= '0;
         r_wr_data    <= '0;
      end else begin
         r_state <= w_next_state;

         if (w_ld_ptr) begin
            r_ptr <= Sw[ADDR_W-1:0];
         end else if (w_inc_ptr) begin
            r_ptr <= r_ptr + 1'b1;   // natural wrap modulo 2^ADDR_W
         end

         if (w_ld_wr) begin
            r_wr_data <= Sw;
         end

         if (w_cap_rd) begin
            r_rd_data <= MemRdData;
         end

         if (w_clr) begin
            r_word_count <= '0;
            r_error      <= 1'b0;
         end else begin
            if (w_inc_ptr && (r_word_count != 8'hFF)) begin
               r_word_count <= r_word_count + 1'b1;
            end
            if (w_set_err) begin
               r_error <= 1'b1;
            end
         end
      end
   end

   // VERIFY runs after Ptr has advanced, so it re-reads Ptr-1 (wraps with Ptr).
   assign MemAddr   = (r_state == ST_VERIFY) ? (r_ptr - 1'b1) : r_ptr;
   assign MemWrData = r_wr_data;
   assign MemWe     = (r_state == ST_WRITE);
   assign MemRe     = (r_state == ST_READ) || (r_state == ST_VERIFY);
   assign RdData    = r_rd_data;
   assign Ptr       = r_ptr;
   assign WordCount = r_word_count;
   assign ProcHold  = (r_state != ST_IDLE);
   assign Error     = r_error;
   assign State     = r_state;

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader. A behavioural memory answers MemWe/MemRe
// after a programmable delay; every expected memory transaction is queued when
// its command is strobed and checked when the memory acknowledges it.
// Honours PROG_LOADER_VERIFY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_prog_loader;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 16;

   localparam logic [1:0] C_SETADDR = 2'b00;
   localparam logic [1:0] C_WRITE   = 2'b01;
   localparam logic [1:0] C_READ    = 2'b10;
   localparam logic [1:0] C_CLEAR   = 2'b11;

   typedef struct {
      logic              is_wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } txn_t;

   logic              Clk;
   logic              Reset_n;
   logic              Strobe;
   logic [1:0]        Cmd;
   logic [DATA_W-1:0] Sw;
   logic [ADDR_W-1:0] MemAddr;
   logic [DATA_W-1:0] MemWrData;
   logic              MemWe;
   logic              MemRe;
   logic              MemAck;
   logic [DATA_W-1:0] MemRdData;
   logic [DATA_W-1:0] RdData;
   logic [ADDR_W-1:0] Ptr;
   logic [7:0]        WordCount;
   logic              ProcHold;
   logic              Error;
   logic [2:0]        State;

   int n_checks = 0;
   int n_errors = 0;

   txn_t              exp_q[$];
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   int                ack_delay  = 3;
   bit                no_ack     = 1'b0;
   bit                inject_ack = 1'b0;
   bit                force_en   = 1'b0;
   logic [DATA_W-1:0] force_val  = '0;
   bit                both_seen  = 1'b0;

   logic [ADDR_W-1:0] m_ptr = '0;
   logic [7:0]        m_wc  = '0;
   logic [DATA_W-1:0] m_rd  = '0;

   prog_loader #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .ACK_TIMEOUT (15)
   ) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Strobe    (Strobe),
      .Cmd       (Cmd),
      .Sw        (Sw),
      .MemAddr   (MemAddr),
      .MemWrData (MemWrData),
      .MemWe     (MemWe),
      .MemRe     (MemRe),
      .MemAck    (MemAck),
      .MemRdData (MemRdData),
      .RdData    (RdData),
      .Ptr       (Ptr),
      .WordCount (WordCount),
      .ProcHold  (ProcHold),
      .Error     (Error),
      .State     (State)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory model: acks on the ack_delay-th cycle of a request, checks the
   // transaction against the scoreboard head.
   initial begin
      int   wait_cnt;
      txn_t t;
      wait_cnt  = 0;
      MemAck    = 1'b0;
      MemRdData = '0;
      forever begin
         @(negedge Clk);
         if (MemWe && MemRe) both_seen = 1'b1;
         if (Reset_n && (MemWe || MemRe)) begin
            wait_cnt++;
            if (!no_ack && wait_cnt >= ack_delay) begin
               MemAck   = 1'b1;
               wait_cnt = 0;
               check("sb_nonempty", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  t = exp_q.pop_front();
                  check("sb_kind", MemWe, t.is_wr);
                  check("sb_addr", MemAddr, t.addr);
                  if (t.is_wr) begin
                     check("sb_wdata", MemWrData, t.data);
                     mem[MemAddr] = MemWrData;
                  end else begin
                     MemRdData = force_en ? force_val : mem[MemAddr];
                  end
               end
            end else begin
               MemAck = 1'b0;
            end
         end else begin
            wait_cnt = 0;
            MemAck   = inject_ack;
         end
      end
   end

   task automatic send(input logic [1:0] c, input logic [DATA_W-1:0] v);
      @(posedge Clk); #1;
      Strobe = 1'b1;
      Cmd    = c;
      Sw     = v;
      @(posedge Clk); #1;
      Strobe = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (State != 3'd0 && n < budget);
      check("wait_idle", State, 0);
   endtask

   // Queue the expected write (and its read-back) then strobe WRITE.
   task automatic do_write(input logic [DATA_W-1:0] d);
      exp_q.push_back('{is_wr: 1'b1, addr: m_ptr, data: d});
`ifdef PROG_LOADER_VERIFY_EN
      exp_q.push_back('{is_wr: 1'b0, addr: m_ptr, data: '0});
`endif
      m_ptr = m_ptr + 1'b1;
      if (m_wc != 8'hFF) m_wc = m_wc + 1'b1;
      send(C_WRITE, d);
   endtask

   task automatic set_addr(input logic [ADDR_W-1:0] a);
      send(C_SETADDR, DATA_W'(a));
      m_ptr = a;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i * 3);
      mem[3]  = 16'h1234;
      Reset_n = 1'b0;
      Strobe  = 1'b0;
      Cmd     = 2'b00;
      Sw      = '0;
      repeat (2) @(negedge Clk);

      // Reset state
      check("rst_state", State, 0);
      check("rst_we", MemWe, 0);
      check("rst_re", MemRe, 0);
      check("rst_ptr", Ptr, 0);
      check("rst_wc", WordCount, 0);
      check("rst_err", Error, 0);
      check("rst_rd", RdData, 0);
      check("rst_wd", MemWrData, 0);
      check("rst_hold", ProcHold, 0);
      @(posedge Clk); #1;
      Reset_n = 1'b1;

      // SETADDR 5, WRITE 0xA5C3 acked after 3 cycles
      set_addr(7'd5);
      @(negedge Clk);
      check("setaddr_ptr", Ptr, 5);
      check("setaddr_state", State, 0);
      do_write(16'hA5C3);
      @(negedge Clk);
      check("wr_we", MemWe, 1);
      check("wr_re", MemRe, 0);
      check("wr_addr", MemAddr, 5);
      check("wr_data", MemWrData, 16'hA5C3);
      check("wr_hold", ProcHold, 1);
      check("wr_state", State, 1);
      wait_idle(60);
      check("wr_ptr", Ptr, m_ptr);
      check("wr_wc", WordCount, m_wc);
      check("wr_err", Error, 0);
`ifdef PROG_LOADER_VERIFY_EN
      m_rd = 16'hA5C3;
      check("vfy_rd", RdData, m_rd);
`endif

      // Pointer wrap from 127 (read-back address is checked by the scoreboard)
      set_addr(7'd127);
      do_write(16'h0BEE);
      wait_idle(60);
      check("wrap_ptr", Ptr, 0);
      check("wrap_wc", WordCount, m_wc);

      // READ at 3 with a strobe issued mid-transfer that must be ignored
      set_addr(7'd3);
      ack_delay = 4;
      exp_q.push_back('{is_wr: 1'b0, addr: 7'd3, data: '0});
      send(C_READ, '0);
      @(negedge Clk);
      check("rd_re", MemRe, 1);
      check("rd_we", MemWe, 0);
      check("rd_state", State, 3);
      check("rd_hold", ProcHold, 1);
      send(C_SETADDR, 16'h0055);
      wait_idle(60);
      m_rd = 16'h1234;
      check("rd_data", RdData, m_rd);
      check("rd_ptr", Ptr, 3);
      @(negedge Clk);
      check("rd_noqueue", State, 0);
      ack_delay = 3;

      // Timeout: no ack, request held exactly 15 cycles
      set_addr(7'd10);
      no_ack = 1'b1;
      send(C_WRITE, 16'h1111);
      hi = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge Clk);
         if (!MemWe) break;
         hi++;
      end
      check("to_cycles", hi, 15);
      check("to_err", Error, 1);
      check("to_ptr", Ptr, 10);
      check("to_wc", WordCount, m_wc);
      check("to_state", State, 0);
      no_ack = 1'b0;
      send(C_CLEAR, '0);
      @(negedge Clk);
      m_wc = '0;
      check("clr_err", Error, 0);
      check("clr_wc", WordCount, 0);

      // Write at 20; with read-back enabled the memory returns a bad word
      set_addr(7'd20);
`ifdef PROG_LOADER_VERIFY_EN
      force_en  = 1'b1;
      force_val = 16'hFFFF;
`endif
      do_write(16'h00FF);
      wait_idle(60);
      force_en = 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
      m_rd = 16'hFFFF;
      check("vfy_err", Error, 1);
`else
      check("wr2_err", Error, 0);
`endif
      check("wr2_rd", RdData, m_rd);
      check("wr2_ptr", Ptr, 21);
      check("wr2_wc", WordCount, m_wc);
      send(C_CLEAR, '0);
      @(negedge Clk);
      m_wc = '0;
      check("clr2_err", Error, 0);

      // Stray MemAck in IDLE is ignored
      @(posedge Clk); #1;
      inject_ack = 1'b1;
      @(posedge Clk); #1;
      inject_ack = 1'b0;
      @(negedge Clk);
      check("idleack_state", State, 0);
      check("idleack_ptr", Ptr, 21);
      check("idleack_rd", RdData, m_rd);
      check("idleack_wc", WordCount, 0);

      // WordCount saturates at 255
      ack_delay = 2;
      for (int i = 0; i < 260; i++) begin
         do_write(DATA_W'(i));
         wait_idle(60);
      end
      check("sat_wc", WordCount, 255);
      check("sat_ptr", Ptr, m_ptr);
      check("sat_err", Error, 0);
      ack_delay = 3;

      // Reset in the middle of a WRITE
      no_ack = 1'b1;
      send(C_WRITE, 16'h7777);
      repeat (2) @(negedge Clk);
      check("mid_we", MemWe, 1);
      #1;
      Reset_n = 1'b0;
      #1;
      check("mr_we", MemWe, 0);
      check("mr_re", MemRe, 0);
      check("mr_state", State, 0);
      check("mr_hold", ProcHold, 0);
      check("mr_ptr", Ptr, 0);
      check("mr_wc", WordCount, 0);
      check("mr_err", Error, 0);
      check("mr_rd", RdData, 0);
      check("mr_wd", MemWrData, 0);
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      no_ack  = 1'b0;
      repeat (2) @(negedge Clk);

      check("sb_drained", exp_q.size(), 0);
      check("we_re_excl", both_seen, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_prog_loader

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 7, instruction-memory address width (matches PC width).
REQ-002 Parameter DATA_W, default 16, instruction word width.
REQ-003 Parameter ACK_TIMEOUT, default 15, maximum cycles to wait for MemAck.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset; ports are listed below.
REQ-005 Clk  input  1  system clock.
REQ-006 Reset_n  input  1  asynchronous active-low reset.
REQ-007 Strobe  input  1  one-cycle command pulse from the key filter.
REQ-008 Cmd  input  2  command: 00 SETADDR, 01 WRITE, 10 READ, 11 CLEAR.
REQ-009 Sw  input  DATA_W  switch value: address in [ADDR_W-1:0], or data word.
REQ-010 MemAddr  output  ADDR_W  memory address.
REQ-011 MemWrData  output  DATA_W  write data.
REQ-012 MemWe  output  1  write request, held until ack.
REQ-013 MemRe  output  1  read request, held until ack.
REQ-014 MemAck  input  1  one-cycle memory acknowledge.
REQ-015 MemRdData  input  DATA_W  read data, valid with MemAck.
REQ-016 RdData  output  DATA_W  last word read, for hex display.
REQ-017 Ptr  output  ADDR_W  current load pointer.
REQ-018 WordCount  output  8  words written since CLEAR, saturating.
REQ-019 ProcHold  output  1  holds the processor while the loader is busy.
REQ-020 Error  output  1  sticky error flag (timeout or verify mismatch).
REQ-021 State  output  3  encoded FSM state, for display.

Function
REQ-022 FSM states SHALL be IDLE, WRITE, VERIFY, READ.
REQ-023 In IDLE, Strobe with SETADDR SHALL load Ptr from Sw[ADDR_W-1:0] on the next edge; the FSM stays in IDLE.
REQ-024 In IDLE, Strobe with WRITE SHALL latch Sw into MemWrData and enter WRITE, asserting MemWe and driving MemAddr=Ptr from the next cycle.
REQ-025 In WRITE, MemAck SHALL deassert MemWe, increment Ptr modulo 2^ADDR_W (wrap from max to 0), increment WordCount (saturate at 255), and go to VERIFY if enabled, else IDLE.
REQ-026 In IDLE, Strobe with READ SHALL enter READ, asserting MemRe at MemAddr=Ptr; on MemAck, RdData SHALL capture MemRdData, Ptr SHALL NOT change, and the FSM returns to IDLE.
REQ-027 In IDLE, Strobe with CLEAR SHALL zero Error and WordCount in one cycle.
REQ-028 Strobe outside IDLE SHALL be ignored (not queued).
REQ-029 If no MemAck arrives within ACK_TIMEOUT cycles of request assertion, the block SHALL drop the request, set Error, and return to IDLE; Ptr and WordCount SHALL be unchanged.
REQ-030 MemWe and MemRe SHALL never be asserted together.
REQ-031 ProcHold SHALL be 1 in every state except IDLE.
REQ-032 MemAck received in IDLE SHALL be ignored.

Reset
REQ-033 Reset_n low SHALL immediately force IDLE; MemWe=0, MemRe=0, Ptr=0, WordCount=0, Error=0, RdData=0, MemWrData=0, ProcHold=0, State=0.
REQ-034 Reset mid-transaction SHALL abort it with no Ptr or WordCount update.

Configuration
REQ-035 With PROG_LOADER_VERIFY_EN defined, WRITE SHALL be followed by VERIFY: MemRe at the just-written address (Ptr-1, wrap-aware); on ack, a MemRdData mismatch with MemWrData sets Error, and RdData captures MemRdData.
REQ-036 Without PROG_LOADER_VERIFY_EN, VERIFY SHALL be absent and WRITE SHALL return directly to IDLE.

Structure
REQ-037 Package prog_loader_pkg SHALL hold the state enum, Cmd encodings and the State output encoding.
REQ-038 Sub-module ack_timer SHALL implement the restartable timeout counter (start, ack, expired).

Verification
REQ-039 SETADDR Sw=0x0005, then WRITE Sw=0xA5C3, ack after 3 cycles -> MemAddr=5, MemWrData=0xA5C3, Ptr=6, WordCount=1.
REQ-040 Ptr=127, WRITE -> Ptr wraps to 0; with VERIFY_EN, verify read is at address 127.
REQ-041 WRITE with no MemAck -> MemWe drops after 15 cycles, Error=1, Ptr unchanged; CLEAR -> Error=0.
REQ-042 READ at Ptr=3, memory returns 0x1234 -> RdData=0x1234, Ptr=3; Strobe during READ is ignored.
REQ-043 VERIFY_EN, memory returns 0xFFFF for written 0x00FF -> Error=1.
REQ-044 Reset_n low during WRITE -> MemWe=0 immediately, all outputs at reset values.
